mxint_block_normalizer: RTL and testbench

MXINT_BLOCK_NORMALIZER -- requirements
Module: mxint_block_normalizer

---
 rtl/mxint_pkg.sv | 21 ++
 rtl/mxint_leading_sign_count.sv | 20 ++
 rtl/mxint_block_normalizer.sv | 149 ++++++++++++++
 tb/tb_mxint_block_normalizer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxint_pkg.sv
// rtl/mxint_pkg.sv - shared MxInt exponent bias and saturation-limit helpers
package mxint_pkg;

   // Biased exponent offset for an exponent field of the given width.
   function automatic int exp_bias(input int width);
      return (1 << (width - 1)) - 1;
   endfunction

   function automatic int exp_max(input int width);
      return (1 << width) - 1;
   endfunction

   function automatic int man_max(input int width);
      return (1 << (width - 1)) - 1;
   endfunction

   function automatic int man_min(input int width);
      return -(1 << (width - 1));
   endfunction

endpackage

// File: rtl/mxint_leading_sign_count.sv
// rtl/mxint_leading_sign_count.sv - minimal two's-complement width of one signed lane
module mxint_leading_sign_count #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0]     value,
   output logic [CNT_WIDTH-1:0] sig_width
);

   // Highest bit differing from the sign bit sets the width; 0 and -1 need one bit.
   always_comb begin
      sig_width = CNT_WIDTH'(1);
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (value[i] != value[WIDTH-1]) begin
            sig_width = CNT_WIDTH'(i + 2);
         end
      end
   end

endmodule

// File: rtl/mxint_block_normalizer.sv
// rtl/mxint_block_normalizer.sv - 2-stage MxInt block renormalizer (wide mantissas to narrow)
module mxint_block_normalizer
   import mxint_pkg::*;
#(
   parameter int BLOCK_SIZE    = 4,
   parameter int IN_MAN_WIDTH  = 16,
   parameter int IN_EXP_WIDTH  = 6,
   parameter int OUT_MAN_WIDTH = 8,
   parameter int OUT_EXP_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [IN_MAN_WIDTH-1:0]  mdata_in_0 [BLOCK_SIZE-1:0],
   input  logic [IN_EXP_WIDTH-1:0]  edata_in_0,
   input  logic                     data_in_0_valid,
   output logic                     data_in_0_ready,
   output logic [OUT_MAN_WIDTH-1:0] mdata_out_0 [BLOCK_SIZE-1:0],
   output logic [OUT_EXP_WIDTH-1:0] edata_out_0,
   output logic                     data_out_0_valid,
   input  logic                     data_out_0_ready
);

   localparam int CW   = $clog2(IN_MAN_WIDTH + 1);
   localparam int EW   = IN_EXP_WIDTH + OUT_EXP_WIDTH + CW + 2;
   localparam int DROP = IN_MAN_WIDTH - OUT_MAN_WIDTH;

   localparam logic signed [EW-1:0] BIAS_DELTA =
      EW'(exp_bias(OUT_EXP_WIDTH) - exp_bias(IN_EXP_WIDTH));
   localparam logic signed [EW-1:0] E_OUT_MAX = EW'(exp_max(OUT_EXP_WIDTH));
   localparam logic [OUT_MAN_WIDTH-1:0] SAT_POS = OUT_MAN_WIDTH'(man_max(OUT_MAN_WIDTH));
   localparam logic [OUT_MAN_WIDTH-1:0] SAT_NEG = OUT_MAN_WIDTH'(man_min(OUT_MAN_WIDTH));

   logic                    v1;
   logic                    v2;
   logic                    s2_ready;

   logic [CW-1:0]           lane_width [BLOCK_SIZE-1:0];
   logic [CW-1:0]           max_width;
   logic [CW-1:0]           lshift;
   logic                    all_zero;

   logic [IN_MAN_WIDTH-1:0] s1_man [BLOCK_SIZE-1:0];
   logic [IN_EXP_WIDTH-1:0] s1_exp;
   logic [CW-1:0]           s1_shift;
   logic                    s1_zero;

   logic signed [EW-1:0]     e_calc;
   logic [OUT_MAN_WIDTH-1:0] s2_man_d [BLOCK_SIZE-1:0];
   logic [OUT_EXP_WIDTH-1:0] s2_exp_d;

   assign s2_ready         = !v2 || data_out_0_ready;
   assign data_in_0_ready  = !v1 || s2_ready;
   assign data_out_0_valid = v2;

   for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_lane
      mxint_leading_sign_count #(
         .WIDTH     (IN_MAN_WIDTH),
         .CNT_WIDTH (CW)
      ) u_lsc (
         .value     (mdata_in_0[g]),
         .sig_width (lane_width[g])
      );
   end

   // Stage 1 combinational: widest lane decides the common left shift.
   always_comb begin
      max_width = CW'(1);
      all_zero  = 1'b1;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         if (lane_width[i] > max_width) begin
            max_width = lane_width[i];
         end
         if (mdata_in_0[i] != '0) begin
            all_zero = 1'b0;
         end
      end
      lshift = CW'(IN_MAN_WIDTH) - max_width;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1       <= 1'b0;
         s1_exp   <= '0;
         s1_shift <= '0;
         s1_zero  <= 1'b0;
         for (int i = 0; i < BLOCK_SIZE; i++) begin
            s1_man[i] <= '0;
         end
      end else if (data_in_0_ready) begin
         v1 <= data_in_0_valid;
         if (data_in_0_valid) begin
            s1_exp   <= edata_in_0;
            s1_shift <= lshift;
            s1_zero  <= all_zero;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
               s1_man[i] <= mdata_in_0[i];
            end
         end
      end
   end

   // Stage 2 combinational: shift/truncate mantissas, rebias exponent, then flush or saturate.
   always_comb begin
      e_calc = $signed({{(EW-IN_EXP_WIDTH){1'b0}}, s1_exp}) + BIAS_DELTA
             - $signed({{(EW-CW){1'b0}}, s1_shift});
      s2_exp_d = '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         s2_man_d[i] = '0;
      end
      if (!s1_zero && !e_calc[EW-1]) begin
         if (e_calc > E_OUT_MAX) begin
            s2_exp_d = '1;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
               if (s1_man[i] == '0) begin
                  s2_man_d[i] = '0;
               end else if (s1_man[i][IN_MAN_WIDTH-1]) begin
                  s2_man_d[i] = SAT_NEG;
               end else begin
                  s2_man_d[i] = SAT_POS;
               end
            end
         end else begin
            s2_exp_d = e_calc[OUT_EXP_WIDTH-1:0];
            for (int i = 0; i < BLOCK_SIZE; i++) begin
               s2_man_d[i] = OUT_MAN_WIDTH'((s1_man[i] << s1_shift) >> DROP);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v2          <= 1'b0;
         edata_out_0 <= '0;
         for (int i = 0; i < BLOCK_SIZE; i++) begin
            mdata_out_0[i] <= '0;
         end
      end else if (s2_ready) begin
         v2 <= v1;
         if (v1) begin
            edata_out_0 <= s2_exp_d;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
               mdata_out_0[i] <= s2_man_d[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_mxint_block_normalizer.sv
// tb/tb_mxint_block_normalizer.sv - directed and random-handshake bench for mxint_block_normalizer
module tb_mxint_block_normalizer;

   logic        clk;
   logic        rst;
   logic [15:0] mdata_in_0 [3:0];
   logic [5:0]  edata_in_0;
   logic        data_in_0_valid;
   logic        data_in_0_ready;
   logic [7:0]  mdata_out_0 [3:0];
   logic [3:0]  edata_out_0;
   logic        data_out_0_valid;
   logic        data_out_0_ready;

   int checks = 0;
   int errors = 0;

   mxint_block_normalizer #(
      .BLOCK_SIZE    (4),
      .IN_MAN_WIDTH  (16),
      .IN_EXP_WIDTH  (6),
      .OUT_MAN_WIDTH (8),
      .OUT_EXP_WIDTH (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .mdata_in_0       (mdata_in_0),
      .edata_in_0       (edata_in_0),
      .data_in_0_valid  (data_in_0_valid),
      .data_in_0_ready  (data_in_0_ready),
      .mdata_out_0      (mdata_out_0),
      .edata_out_0      (edata_out_0),
      .data_out_0_valid (data_out_0_valid),
      .data_out_0_ready (data_out_0_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic set_block(input logic [63:0] lanes, input logic [5:0] e);
      for (int i = 0; i < 4; i++) mdata_in_0[i] = lanes[16*i +: 16];
      edata_in_0 = e;
   endtask

   function automatic logic [35:0] out_word();
      return {edata_out_0, mdata_out_0[3], mdata_out_0[2], mdata_out_0[1], mdata_out_0[0]};
   endfunction

   // Drives one block into an empty pipeline; returns output-valid seen one cycle after accept.
   task automatic send_single(input logic [63:0] lanes, input logic [5:0] e, output logic early_valid);
      set_block(lanes, e);
      data_in_0_valid = 1'b1;
      @(posedge clk); #1;
      data_in_0_valid = 1'b0;
      early_valid = data_out_0_valid;
      @(posedge clk); #1;
   endtask

   // Independent value-domain model of one block.
   function automatic logic [35:0] model(input logic [63:0] lanes, input int e);
      int v [4];
      int w, wmax, l, eo, r;
      logic [31:0] om;
      bit allz;
      wmax = 1;
      allz = 1'b1;
      for (int i = 0; i < 4; i++) begin
         v[i] = int'($signed(lanes[16*i +: 16]));
         if (v[i] != 0) allz = 1'b0;
         w = 1;
         while (!(v[i] >= -(1 << (w - 1)) && v[i] <= (1 << (w - 1)) - 1)) w++;
         if (w > wmax) wmax = w;
      end
      l  = 16 - wmax;
      eo = e - 31 + 7 - l;
      if (allz || eo < 0) return 36'd0;
      om = '0;
      for (int i = 0; i < 4; i++) begin
         if (eo > 15) r = (v[i] == 0) ? 0 : ((v[i] < 0) ? -128 : 127);
         else         r = (v[i] * (1 << l)) >>> 8;
         om[8*i +: 8] = r[7:0];
      end
      return {(eo > 15) ? 4'hF : eo[3:0], om};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      data_in_0_valid = 1'b0;
      data_out_0_ready = 1'b1;
      set_block(64'd0, 6'd0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (data_out_0_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b expected 0", data_out_0_valid);
      end
      checks++;
      if (out_word() !== 36'd0) begin
         errors++; $display("FAIL reset_data: got %h expected %h", out_word(), 36'd0);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (data_in_0_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b expected 1", data_in_0_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic ev;
      send_single(64'h0000_0010_FF00_0100, 6'd31, ev);
      checks++;
      if (ev !== 1'b0) begin
         errors++; $display("FAIL basic_latency: valid after 1 cycle got %b expected 0", ev);
      end
      checks++;
      if (data_out_0_valid !== 1'b1) begin
         errors++; $display("FAIL basic_valid: got %b expected 1", data_out_0_valid);
      end
      checks++;
      if (out_word() !== {4'd1, 32'h00_04_C0_40}) begin
         errors++; $display("FAIL basic_data: got %h expected %h", out_word(), {4'd1, 32'h00_04_C0_40});
      end
      @(posedge clk); #1;
      checks++;
      if (data_out_0_valid !== 1'b0) begin
         errors++; $display("FAIL basic_drain: got %b expected 0", data_out_0_valid);
      end
   endtask

   task automatic test_flush();
      logic ev;
      send_single(64'h0000_0000_0000_0001, 6'd20, ev);
      checks++;
      if (data_out_0_valid !== 1'b1 || out_word() !== 36'd0) begin
         errors++; $display("FAIL flush: got v=%b %h expected v=1 %h", data_out_0_valid, out_word(), 36'd0);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_saturate();
      logic ev;
      send_single(64'h0005_0000_C000_4000, 6'd63, ev);
      checks++;
      if (data_out_0_valid !== 1'b1 || out_word() !== {4'hF, 32'h7F_00_80_7F}) begin
         errors++; $display("FAIL saturate: got v=%b %h expected v=1 %h", data_out_0_valid, out_word(), {4'hF, 32'h7F_00_80_7F});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_zero_block();
      logic ev;
      send_single(64'd0, 6'd40, ev);
      checks++;
      if (data_out_0_valid !== 1'b1 || out_word() !== 36'd0) begin
         errors++; $display("FAIL zero_block: got v=%b %h expected v=1 %h", data_out_0_valid, out_word(), 36'd0);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_exp_edges();
      logic [63:0] lanes [7];
      logic [5:0]  ev_in [7];
      logic [35:0] expw  [7];
      logic        ev;
      lanes[0] = 64'h0000_0000_0000_4000; ev_in[0] = 6'd24; expw[0] = {4'd0, 32'h0000_0040};
      lanes[1] = 64'h0000_0000_0000_4000; ev_in[1] = 6'd39; expw[1] = {4'hF, 32'h0000_0040};
      lanes[2] = 64'h0000_0000_0000_4000; ev_in[2] = 6'd40; expw[2] = {4'hF, 32'h0000_007F};
      lanes[3] = 64'h0000_0000_0000_4000; ev_in[3] = 6'd23; expw[3] = 36'd0;
      lanes[4] = 64'hFFFF_FFFF_FFFF_FFFF; ev_in[4] = 6'd40; expw[4] = {4'd1, 32'h8080_8080};
      lanes[5] = 64'h0000_0000_0000_8000; ev_in[5] = 6'd31; expw[5] = {4'd7, 32'h0000_0080};
      lanes[6] = 64'h0000_0000_FF01_7FFF; ev_in[6] = 6'd31; expw[6] = {4'd7, 32'h0000_FF7F};
      for (int k = 0; k < 7; k++) begin
         send_single(lanes[k], ev_in[k], ev);
         checks++;
         if (data_out_0_valid !== 1'b1 || out_word() !== expw[k]) begin
            errors++;
            $display("FAIL exp_edge[%0d]: got v=%b %h expected v=1 %h", k, data_out_0_valid, out_word(), expw[k]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      logic [35:0] wa, wb, wc;
      wa = {4'd1, 32'h00_04_C0_40};
      wb = {4'hF, 32'h7F_00_80_7F};
      wc = {4'd8, 32'h00_00_00_40};
      data_out_0_ready = 1'b0;
      set_block(64'h0000_0010_FF00_0100, 6'd31);
      data_in_0_valid = 1'b1;
      #1;
      checks++;
      if (data_in_0_ready !== 1'b1) begin
         errors++; $display("FAIL bp_ready0: got %b expected 1", data_in_0_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (data_in_0_ready !== 1'b1) begin
         errors++; $display("FAIL bp_ready1: got %b expected 1", data_in_0_ready);
      end
      set_block(64'h0005_0000_C000_4000, 6'd63);
      @(posedge clk); #1;
      set_block(64'h0000_0000_0000_0040, 6'd40);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (data_in_0_ready !== 1'b0 || data_out_0_valid !== 1'b1 || out_word() !== wa) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got rdy=%b v=%b %h expected rdy=0 v=1 %h",
                     k, data_in_0_ready, data_out_0_valid, out_word(), wa);
         end
         @(posedge clk); #1;
      end
      data_out_0_ready = 1'b1;
      @(posedge clk); #1;
      data_in_0_valid = 1'b0;
      checks++;
      if (data_out_0_valid !== 1'b1 || out_word() !== wb) begin
         errors++; $display("FAIL bp_second: got v=%b %h expected v=1 %h", data_out_0_valid, out_word(), wb);
      end
      @(posedge clk); #1;
      checks++;
      if (data_out_0_valid !== 1'b1 || out_word() !== wc) begin
         errors++; $display("FAIL bp_third: got v=%b %h expected v=1 %h", data_out_0_valid, out_word(), wc);
      end
      @(posedge clk); #1;
      checks++;
      if (data_out_0_valid !== 1'b0) begin
         errors++; $display("FAIL bp_empty: got %b expected 0", data_out_0_valid);
      end
   endtask

   task automatic test_reset_midstream();
      data_out_0_ready = 1'b0;
      set_block(64'h0000_0010_FF00_0100, 6'd31);
      data_in_0_valid = 1'b1;
      @(posedge clk); #1;
      set_block(64'h0005_0000_C000_4000, 6'd63);
      @(posedge clk); #1;
      data_in_0_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (data_out_0_valid !== 1'b0 || out_word() !== 36'd0) begin
         errors++; $display("FAIL midrst_clear: got v=%b %h expected v=0 %h", data_out_0_valid, out_word(), 36'd0);
      end
      rst = 1'b0;
      data_out_0_ready = 1'b1;
      #1;
      checks++;
      if (data_in_0_ready !== 1'b1) begin
         errors++; $display("FAIL midrst_ready: got %b expected 1", data_in_0_ready);
      end
      set_block(64'h0000_0000_0000_0040, 6'd40);
      data_in_0_valid = 1'b1;
      @(posedge clk); #1;
      data_in_0_valid = 1'b0;
      checks++;
      if (data_out_0_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_latency: got %b expected 0", data_out_0_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (data_out_0_valid !== 1'b1 || out_word() !== {4'd8, 32'h00_00_00_40}) begin
         errors++;
         $display("FAIL midrst_block: got v=%b %h expected v=1 %h", data_out_0_valid, out_word(), {4'd8, 32'h00_00_00_40});
      end
      @(posedge clk); #1;
      checks++;
      if (data_out_0_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_stale: got %b expected 0", data_out_0_valid);
      end
   endtask

   task automatic test_random();
      logic [63:0]        lanes;
      logic [5:0]         e;
      logic signed [15:0] t;
      int unsigned        r;
      logic [35:0]        q [$];
      bit                 have;
      int                 sent, recv, cyc;
      have = 1'b0; sent = 0; recv = 0; cyc = 0;
      lanes = '0; e = '0;
      while (recv < 20 && cyc < 2000) begin
         if (!have && sent < 20 && $urandom_range(0, 3) != 0) begin
            for (int i = 0; i < 4; i++) begin
               r = $urandom;
               t = $signed(r[15:0]) >>> $urandom_range(0, 15);
               if ($urandom_range(0, 4) == 0) t = '0;
               lanes[16*i +: 16] = t;
            end
            e = 6'($urandom_range(14, 56));
            set_block(lanes, e);
            have = 1'b1;
         end
         data_in_0_valid  = have;
         data_out_0_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (data_out_0_valid && data_out_0_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL random_extra: got %h expected no block", out_word());
            end else begin
               if (out_word() !== q[0]) begin
                  errors++; $display("FAIL random_block[%0d]: got %h expected %h", recv, out_word(), q[0]);
               end
               void'(q.pop_front());
            end
            recv++;
         end
         if (have && data_in_0_ready) begin
            q.push_back(model(lanes, int'(e)));
            have = 1'b0;
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      data_in_0_valid  = 1'b0;
      data_out_0_ready = 1'b1;
      checks++;
      if (recv != 20) begin
         errors++; $display("FAIL random_count: got %0d blocks expected 20", recv);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_flush();
      test_saturate();
      test_zero_block();
      test_exp_edges();
      test_backpressure();
      test_reset_midstream();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
